// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control sequencer:
// opcodes, funcs, ALU codes, datapath mux selects and the FSM state code.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_LUI = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PC_SRC_SEQ = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_JMP = 2'd2;
  localparam logic [1:0] PC_SRC_RS  = 2'd3;

  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_RS    = 2'd1;
  localparam logic [1:0] SRC_A_SHAMT = 2'd2;

  localparam logic [1:0] SRC_B_RT     = 2'd0;
  localparam logic [1:0] SRC_B_FOUR   = 2'd1;
  localparam logic [1:0] SRC_B_IMM    = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MDR = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_ALU = 4'd7,
    S_WB_MEM = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_JAL    = 4'd11,
    S_JR     = 4'd12,
    S_TRAP   = 4'd15
  } state_t;

  typedef enum logic [2:0] {
    CLS_R_ALU,
    CLS_I_ALU,
    CLS_MEM,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_JAL,
    CLS_JR,
    CLS_NONE
  } iclass_t;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Instruction/status inputs and datapath control outputs between the
// sequencer (master) and the shared datapath (slave).
interface mc_ctrl_fsm_if;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       i_or_d;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem2reg;

  modport master (
    input  opcode, func, zero, mem_ready,
    output mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_control, reg_write, reg_dst, mem2reg
  );

  modport slave (
    output opcode, func, zero, mem_ready,
    input  mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_control, reg_write, reg_dst, mem2reg
  );
endinterface

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/func to instruction class,
// ALU operation for the execute step, and a legal-instruction flag.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output iclass_t    iclass,
  output logic [2:0] alu_op,
  output logic       legal
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    iclass = CLS_NONE;
    alu_op = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        case (func)
          FN_ADD:  begin iclass = CLS_R_ALU; alu_op = ALU_ADD; end
          FN_SUB:  begin iclass = CLS_R_ALU; alu_op = ALU_SUB; end
          FN_AND:  begin iclass = CLS_R_ALU; alu_op = ALU_AND; end
          FN_OR:   begin iclass = CLS_R_ALU; alu_op = ALU_OR;  end
          FN_SLT:  begin iclass = CLS_R_ALU; alu_op = ALU_SLT; end
          FN_SRL:  begin iclass = CLS_R_ALU; alu_op = ALU_SRL; end
          FN_JR:   iclass = CLS_JR;
          default: iclass = CLS_NONE;
        endcase
      end
      OP_ADDI: begin iclass = CLS_I_ALU; alu_op = ALU_ADD; end
      OP_ANDI: begin iclass = CLS_I_ALU; alu_op = ALU_AND; end
      OP_ORI:  begin iclass = CLS_I_ALU; alu_op = ALU_OR;  end
      OP_SLTI: begin iclass = CLS_I_ALU; alu_op = ALU_SLT; end
      OP_LUI:  begin iclass = CLS_I_ALU; alu_op = ALU_LUI; end
      OP_LW, OP_SW:   iclass = CLS_MEM;
      OP_BEQ, OP_BNE: iclass = CLS_BRANCH;
      OP_J:    iclass = CLS_JUMP;
      OP_JAL:  iclass = CLS_JAL;
      default: iclass = CLS_NONE;
    endcase
  end

  assign legal = (iclass != CLS_NONE);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer for the MIPS-subset CPU.
// Optional MC_CTRL_ILLEGAL_TRAP_EN: unknown instructions trap instead of acting as NOPs.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  mc_ctrl_fsm_if.master     bus,
  output logic [3:0]        state_out,
  output logic              illegal,
  output logic [CNT_W-1:0]  instr_count
);

  state_t     state, state_nxt;
  logic       retire;
  iclass_t    iclass;
  logic [2:0] alu_op;
  logic       legal;

  mc_decode u_decode (
    .opcode (bus.opcode),
    .func   (bus.func),
    .iclass (iclass),
    .alu_op (alu_op),
    .legal  (legal)
  );

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      S_FETCH:  if (bus.mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        if (!legal) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          state_nxt = S_TRAP;
`else
          state_nxt = S_FETCH;
          retire    = 1'b1;
`endif
        end else begin
          case (iclass)
            CLS_R_ALU:  state_nxt = S_EXEC_R;
            CLS_I_ALU:  state_nxt = S_EXEC_I;
            CLS_MEM:    state_nxt = S_ADDR;
            CLS_BRANCH: state_nxt = S_BRANCH;
            CLS_JUMP:   state_nxt = S_JUMP;
            CLS_JAL:    state_nxt = S_JAL;
            CLS_JR:     state_nxt = S_JR;
            default:    state_nxt = S_FETCH;
          endcase
        end
      end
      S_EXEC_R, S_EXEC_I: state_nxt = S_WB_ALU;
      S_ADDR:   state_nxt = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (bus.mem_ready) state_nxt = S_WB_MEM;
      S_MEM_WR: if (bus.mem_ready) begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP, S_JAL, S_JR: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_TRAP:   state_nxt = S_TRAP;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    instr_count <= '0;
    else if (retire) instr_count <= instr_count + CNT_W'(1);
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          illegal <= 1'b0;
    else if (state == S_DECODE && !legal) illegal <= 1'b1;
  end
`else
  assign illegal = 1'b0;
`endif

  // Outputs are forced low while reset_n is held so nothing is written mid-reset.
  always_comb begin
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.i_or_d      = 1'b0;
    bus.ir_write    = 1'b0;
    bus.pc_write    = 1'b0;
    bus.pc_src      = PC_SRC_SEQ;
    bus.alu_src_a   = SRC_A_PC;
    bus.alu_src_b   = SRC_B_RT;
    bus.alu_control = ALU_ADD;
    bus.reg_write   = 1'b0;
    bus.reg_dst     = DST_RT;
    bus.mem2reg     = M2R_ALU;
    if (reset_n) begin
      case (state)
        S_FETCH: begin
          bus.mem_req   = 1'b1;
          bus.alu_src_b = SRC_B_FOUR;
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
        end
        S_DECODE: bus.alu_src_b = SRC_B_IMM_SH;
        S_EXEC_R: begin
          bus.alu_src_a   = (bus.func == FN_SRL) ? SRC_A_SHAMT : SRC_A_RS;
          bus.alu_control = alu_op;
        end
        S_EXEC_I: begin
          bus.alu_src_a   = SRC_A_RS;
          bus.alu_src_b   = SRC_B_IMM;
          bus.alu_control = alu_op;
        end
        S_ADDR: begin
          bus.alu_src_a = SRC_A_RS;
          bus.alu_src_b = SRC_B_IMM;
        end
        S_MEM_RD: begin
          bus.mem_req = 1'b1;
          bus.i_or_d  = 1'b1;
        end
        S_MEM_WR: begin
          bus.mem_req = 1'b1;
          bus.mem_we  = 1'b1;
          bus.i_or_d  = 1'b1;
        end
        S_WB_ALU: begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = (bus.opcode == OP_RTYPE) ? DST_RD : DST_RT;
        end
        S_WB_MEM: begin
          bus.reg_write = 1'b1;
          bus.mem2reg   = M2R_MDR;
        end
        S_BRANCH: begin
          bus.alu_src_a   = SRC_A_RS;
          bus.alu_control = ALU_SUB;
          bus.pc_src      = PC_SRC_BR;
          bus.pc_write    = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
        end
        S_JUMP: begin
          bus.pc_write = 1'b1;
          bus.pc_src   = PC_SRC_JMP;
        end
        S_JAL: begin
          bus.pc_write  = 1'b1;
          bus.pc_src    = PC_SRC_JMP;
          bus.reg_write = 1'b1;
          bus.reg_dst   = DST_RA;
          bus.mem2reg   = M2R_PC;
        end
        S_JR: begin
          bus.pc_write = 1'b1;
          bus.pc_src   = PC_SRC_RS;
        end
        default: ;
      endcase
    end
  end

  assign state_out = reset_n ? state : 4'd0;

endmodule
